fft16_frame_ctrl: RTL

- Frame sequencer for the 16-point radix-2 FFT datapath (stage1..stage4 chain, 32-bit {real[31:16], imag[15:0]} words).
- Collects 16 serial real input samples into a frame buffer and presents them in parallel to the datapath.
- Waits the datapath latency, captures the 16 results, then streams them out serially in natural frequency order with valid/ready backpressure.
- The stage4 output is bit-reversed, so the controller undoes the reordering.

---
 rtl/fft16_frame_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fft16_frame_ctrl.sv
// fft16_frame_ctrl: frame sequencer for the 16-point radix-2 FFT chain.
// Collects 16 real samples, fires the datapath, waits LAT cycles, then
// drains the results in natural frequency order (undoing bit reversal).
// Ports: clk, rst (async active-low); in_valid/in_data/in_ready sample
// input; fft_x/fft_start/fft_y datapath link; out_valid/out_data/out_idx/
// out_ready result stream; frame_done one-cycle end-of-frame pulse.
module fft16_frame_ctrl #(
  parameter int N   = 16,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [32*N-1:0] fft_x,
  output logic            fft_start,
  input  logic [32*N-1:0] fft_y,
  output logic            out_valid,
  output logic [31:0]     out_data,
  output logic [3:0]      out_idx,
  input  logic            out_ready,
  output logic            frame_done
);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      state;
  logic [31:0] frame_q [N];
  logic [31:0] res_q [N];
  logic [3:0]  wr_cnt;
  logic [3:0]  rd_cnt;
  logic [7:0]  lat_cnt;

  // stage4 leaves slot k holding frequency bitrev4(k)
  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  always_comb begin
    fft_x = '0;
    for (int i = 0; i < N; i++)
      fft_x[32*i +: 32] = frame_q[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_COLLECT;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      lat_cnt    <= '0;
      in_ready   <= 1'b0;
      fft_start  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < N; i++) begin
        frame_q[i] <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        S_COLLECT: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            frame_q[wr_cnt] <= {16'(in_data), 16'h0000};
            if (wr_cnt == 4'd15) begin
              wr_cnt    <= '0;
              in_ready  <= 1'b0;
              fft_start <= 1'b1;
              lat_cnt   <= '0;
              state     <= S_WAIT;
            end else begin
              wr_cnt <= wr_cnt + 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt == 8'(LAT)) begin
            for (int i = 0; i < N; i++)
              res_q[i] <= fft_y[32*i +: 32];
            // slot 0 is frequency 0, so the first word needs no reorder
            out_data  <= fft_y[31:0];
            out_idx   <= '0;
            out_valid <= 1'b1;
            rd_cnt    <= '0;
            state     <= S_DRAIN;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (rd_cnt == 4'd15) begin
              rd_cnt     <= '0;
              out_valid  <= 1'b0;
              out_data   <= '0;
              out_idx    <= '0;
              frame_done <= 1'b1;
              in_ready   <= 1'b1;
              state      <= S_COLLECT;
            end else begin
              rd_cnt   <= rd_cnt + 4'd1;
              out_idx  <= rd_cnt + 4'd1;
              out_data <= res_q[bitrev4(rd_cnt + 4'd1)];
            end
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule
